road_scroller: RTL and testbench



---
 rtl/road_scroller.sv | 79 +++++++
 tb/tb_road_scroller.sv | 111 +++++++++++
 2 files changed

// File: rtl/road_scroller.sv
// road_scroller: speed-controlled road background with scrolling dashed lane marks
// plus the per-frame speed, scroll and odometer state used by the sprite and HUD blocks.
module road_scroller #(
   parameter int ROAD_XSTART  = 256,
   parameter int ROAD_XEND    = 511,
   parameter int LANES        = 2,
   parameter int KERB_W       = 4,
   parameter int MARK_W       = 8,
   parameter int MARK_PERIOD  = 64,
   parameter int MARK_LEN     = 42,
   parameter int SPEED_W      = 4,
   parameter int MAX_SPEED    = 15,
   parameter int SCROLL_W     = 10,
   parameter int COAST_FRAMES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic                accel,
   input  logic                brake,
   input  logic                video_on,
   input  logic [9:0]          pixel_x,
   input  logic [9:0]          pixel_y,
   output logic [2:0]          rgb,
   output logic [SPEED_W-1:0]  speed,
   output logic [SCROLL_W-1:0] scroll,
   output logic [15:0]         distance
);
   localparam int LW = (ROAD_XEND - ROAD_XSTART + 1) / LANES;
   localparam int CW = $clog2(COAST_FRAMES);
   localparam int PW = $clog2(MARK_PERIOD);

   logic [CW-1:0]      coast, coast_inc;
   logic [SPEED_W-1:0] speed_nxt;
   logic [16:0]        dist_sum;
   logic [PW-1:0]      phase;
   logic               in_mark;
   logic [2:0]         rgb_nxt;

   always_comb begin
      coast_inc = coast + CW'(1);
      speed_nxt = brake ? (speed > SPEED_W'(2) ? speed - SPEED_W'(2) : '0)
                : accel ? (speed < SPEED_W'(MAX_SPEED) ? speed + SPEED_W'(1) : SPEED_W'(MAX_SPEED))
                : (coast_inc == '0 && speed != '0) ? speed - SPEED_W'(1) : speed;
      dist_sum  = {1'b0, distance} + 17'(speed);
   end

   // Only the low bits matter because the dash period is a power of two.
   assign phase = pixel_y[PW-1:0] - scroll[PW-1:0];

   always_comb begin
      in_mark = 1'b0;
      for (int k = 1; k < LANES; k++)
         if (pixel_x >= 10'(ROAD_XSTART + k*LW - MARK_W/2) && pixel_x <= 10'(ROAD_XSTART + k*LW + MARK_W/2 - 1))
            in_mark = 1'b1;
      rgb_nxt = !video_on ? 3'b000
              : (pixel_x < 10'(ROAD_XSTART) || pixel_x > 10'(ROAD_XEND)) ? 3'b010
              : (pixel_x < 10'(ROAD_XSTART + KERB_W) || pixel_x > 10'(ROAD_XEND - KERB_W)) ? 3'b111
              : (in_mark && phase < PW'(MARK_LEN)) ? 3'b110 : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb      <= '0;
         speed    <= '0;
         scroll   <= '0;
         distance <= '0;
         coast    <= '0;
      end else begin
         rgb <= rgb_nxt;
         if (frame_tick) begin
            scroll   <= scroll + SCROLL_W'(speed);
            distance <= dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
            speed    <= speed_nxt;
            coast    <= (accel || brake) ? '0 : coast_inc;
         end
      end
   end
endmodule

// File: tb/tb_road_scroller.sv
// tb_road_scroller: directed checks of road_scroller pixel map and per-frame speed/scroll/odometer.
module tb_road_scroller;
   logic       clk = 0, reset = 0, frame_tick = 0, accel = 0, brake = 0, video_on = 0;
   logic [9:0] pixel_x = 0, pixel_y = 0;
   logic [2:0] rgb;
   logic [3:0] speed;
   logic [9:0] scroll;
   logic [15:0] distance;
   int checks = 0, errors = 0;
   int ms = 0, mscroll = 0, mdist = 0;

   road_scroller dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .accel(accel), .brake(brake),
      .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .rgb(rgb), .speed(speed), .scroll(scroll), .distance(distance)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Scroll/odometer advance by the speed held before the tick; nxt is the hand-computed new speed.
   task automatic tick(input logic a, input logic b, input int nxt);
      mscroll = (mscroll + ms) % 1024;
      mdist = (mdist + ms > 65535) ? 65535 : mdist + ms;
      ms = nxt;
      @(negedge clk);
      frame_tick = 1; accel = a; brake = b;
      @(negedge clk);
      frame_tick = 0; accel = 0; brake = 0;
      chk("speed", speed, nxt);
      chk("scroll", scroll, mscroll);
      chk("distance", distance, mdist);
   endtask

   task automatic px(input string tag, input logic vo, input int x, input int y, input int exp);
      @(negedge clk);
      video_on = vo; pixel_x = 10'(x); pixel_y = 10'(y);
      @(negedge clk);
      chk(tag, rgb, exp);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1; frame_tick = 1; accel = 1; video_on = 1; pixel_x = 100;
      repeat (cycles) @(negedge clk);
      reset = 0; frame_tick = 0; accel = 0; video_on = 0;
      ms = 0; mscroll = 0; mdist = 0;
      chk("rst_rgb", rgb, 0);
      chk("rst_speed", speed, 0);
      chk("rst_scroll", scroll, 0);
      chk("rst_distance", distance, 0);
   endtask

   initial begin
      do_reset(3);
      px("px_grass_l", 1, 100, 0, 3'b010);
      px("px_kerb_l", 1, 257, 0, 3'b111);
      px("px_asphalt", 1, 300, 0, 3'b000);
      px("px_mark_y41", 1, 380, 41, 3'b110);
      px("px_mark_x387", 1, 387, 0, 3'b110);
      px("px_mark_x388", 1, 388, 0, 3'b000);
      px("px_mark_x379", 1, 379, 0, 3'b000);
      px("px_gap_y42", 1, 380, 42, 3'b000);
      px("px_kerb_r", 1, 508, 0, 3'b111);
      px("px_grass_r", 1, 512, 0, 3'b010);
      px("px_blank", 0, 380, 0, 3'b000);
      for (int i = 0; i < 20; i++) tick(1, 0, (i + 1 > 15) ? 15 : i + 1);
      chk("accel_scroll", scroll, 180);
      chk("accel_distance", distance, 180);
      repeat (5) @(negedge clk);
      chk("stable_scroll", scroll, 180);
      for (int i = 0; i < 56; i++) tick(1, 0, 15);
      chk("pre_wrap", scroll, 1020);
      tick(0, 1, 13);
      chk("wrap_scroll", scroll, 11);
      chk("wrap_distance", distance, 1035);
      px("wrap_y5", 1, 380, 5, 3'b000);
      px("wrap_y10", 1, 380, 10, 3'b000);
      px("wrap_y11", 1, 380, 11, 3'b110);
      px("wrap_y52", 1, 380, 52, 3'b110);
      px("wrap_y53", 1, 380, 53, 3'b000);
      tick(0, 1, 11); tick(0, 1, 9); tick(0, 1, 7); tick(0, 1, 5);
      tick(1, 1, 3);
      tick(0, 1, 1);
      tick(0, 1, 0);
      tick(0, 1, 0);
      for (int i = 1; i <= 4; i++) tick(1, 0, i);
      repeat (7) tick(0, 0, 4);
      tick(0, 0, 3);
      repeat (4) tick(0, 0, 3);
      tick(1, 0, 4);
      repeat (7) tick(0, 0, 4);
      tick(0, 0, 3);
      do_reset(1);
      for (int i = 0; i < 15; i++) tick(1, 0, i + 1);
      while (mdist < 65528) tick(1, 0, 15);
      tick(1, 0, 15);
      chk("sat_distance", distance, 16'hFFFF);
      tick(1, 0, 15);
      chk("sat_hold", distance, 16'hFFFF);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
